uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver; consumes the tx line of uart_transmitter (looped or external).
//  Frame: start(0), 8 data bits LSB first, parity slot, stop(1) = 11 bit times.
//  Oversamples rx, mid-bit samples each bit, presents byte on a valid/ready output with error flags.
// PARAMETERS
//  OVERSAMPLE  16  sample_tick pulses per bit time; even, >=4
//  CNT_W       4   width of tick counter; must hold OVERSAMPLE-1
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  sample_tick  in   1  1-clk enable pulse at OVERSAMPLE x baud
//  rx           in   1  asynchronous serial input, idle high
//  data_out     out  8  received byte, held until next accepted frame
//  valid        out  1  data_out holds an unconsumed byte
//  ready        in   1  consumer accepts byte when valid&&ready
//  frame_err    out  1  1-clk pulse: stop bit sampled 0
//  parity_err   out  1  1-clk pulse: parity mismatch (macro only, else tied 0)
//  overrun_err  out  1  1-clk pulse: new byte completed while valid still high
// BEHAVIOUR
//  Reset: state=IDLE, counters 0, data_out=8'h00, valid=0, all err=0, synchroniser flops=1.
//  rx passes through 2-flop synchroniser (rx_s); all decisions use rx_s; FSM/counters advance only on sample_tick.
//  IDLE: rx_s==0 on a tick -> START, tick_cnt=0.
//  START: after OVERSAMPLE/2 ticks re-sample rx_s; 0 -> DATA (bit_cnt=0, tick_cnt=0); 1 -> IDLE (glitch, no flag).
//  DATA: sample every OVERSAMPLE ticks (mid-bit); shift into shift_reg[bit_cnt]; after bit_cnt==7 -> PARITY.
//  PARITY: sample after OVERSAMPLE ticks into par_bit -> STOP.
//  STOP: sample after OVERSAMPLE ticks:
//   1 -> load data_out, set valid, IDLE; if valid already 1 and not consumed this clk -> overrun_err pulse, data overwritten.
//   0 -> frame_err pulse, data_out/valid unchanged, -> WAIT_HIGH.
//  WAIT_HIGH: stay until rx_s==1 on a tick -> IDLE (prevents break condition retriggering).
//  valid: set on clk after the STOP sampling tick; cleared on clk after valid&&ready; set has priority over clear same clk.
//  Latency: valid rises 1 clk after the stop-bit mid-sample tick (~10.5 bit times after start falling edge, +2 clk sync).
//  tick_cnt wraps at OVERSAMPLE-1 back to 0; no tick -> all state held.
//  rst_n low mid-frame: immediate return to reset values; partial byte discarded.
// CONFIGURATION
//  UART_RX_PARITY_CHECK_EN defined: parity slot checked as even parity over data (expected = ^data);
//   mismatch -> parity_err pulse alongside load; byte still delivered.
//  Not defined: parity slot sampled and discarded; parity_err tied 0.
// STRUCTURE
//  Package uart_pkg: state encoding (IDLE,START,DATA,PARITY,STOP,WAIT_HIGH), DATA_BITS=8, FRAME_BITS=11.
//  Sub-module uart_rx_sync: 2-flop synchroniser, async reset to 1.
//  FSM, tick_cnt, bit_cnt, shift_reg, output register in top.
// TESTING
//  Loop uart_transmitter tx->rx, data 8'hA5, OVERSAMPLE=16 -> one valid, data_out=8'hA5, no err.
//  rx low pulse of 4 ticks in IDLE -> return to IDLE, no valid, no flags.
//  Frame 8'h3C with stop forced 0 -> frame_err 1 clk, valid stays 0, waits for rx high.
//  Two frames 8'h11, 8'h22 with ready=0 -> overrun_err on second, data_out=8'h22, valid=1.
//  Macro on, frame 8'h01 with parity slot 0 -> parity_err pulse, data_out=8'h01; macro off -> no flag.
//  rst_n asserted at data bit 4 -> valid=0, data_out=8'h00; next full frame 8'h5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
//   rx_state_e : receiver FSM state encoding
//   DATA_BITS  : payload bits per frame
//   FRAME_BITS : start + data + parity slot + stop
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   rx_i   in  raw asynchronous serial line
//   rx_s_o out synchronised serial line
// Both flops reset to 1 (line idle level) so leaving reset cannot look
// like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: clocked state uses non-blocking assignments so both flops sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, 8 data bits LSB first, parity slot,
// stop. Each bit is sampled once near its middle; the received byte is
// presented on a valid/ready interface with single-cycle error pulses.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sample_tick  1-clk enable at OVERSAMPLE x baud
//   rx           asynchronous serial input, idle high
//   data_out     last received byte, held until the next good frame
//   valid/ready  output handshake; byte consumed when both high
//   frame_err    pulse: stop bit sampled low
//   parity_err   pulse: even-parity mismatch (tied 0 unless enabled)
//   overrun_err  pulse: new byte completed while the old one was unconsumed
// Build option: define UART_RX_PARITY_CHECK_EN to check the parity slot as
// even parity over the data; otherwise the slot is skipped unchecked.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err
);

  localparam int BIT_W = $clog2(DATA_BITS);

  rx_state_e                state_q;
  logic [CNT_W-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]     shift_reg_q;
  logic [DATA_BITS-1:0]     data_out_q;
  logic                     valid_q;
  logic                     frame_err_q;
  logic                     overrun_err_q;
  logic                     rx_s;
  logic                     tick_last;
  logic                     tick_half;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  // START waits half a bit so every later sample lands mid-bit.
  assign tick_half = (tick_cnt_q == CNT_W'(OVERSAMPLE/2 - 1));
  assign tick_last = (tick_cnt_q == CNT_W'(OVERSAMPLE - 1));

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (tick_last) tick_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q + 1'b1;
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic par_bit_q;
  logic parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_reg_q   <= '0;
      data_out_q    <= 8'h00;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par_bit_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      parity_err_q  <= 1'b0;
`endif
      // Consumption clear comes first so a same-cycle load below wins.
      if (valid_q && ready) valid_q <= 1'b0;

      if (sample_tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q    <= START;
              tick_cnt_q <= '0;
            end
          end
          START: begin
            if (tick_half) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              // A line back high at mid-start was a glitch; drop silently.
              state_q    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end
          DATA: begin
            tick_cnt_q <= tick_cnt_d;
            if (tick_last) begin
              shift_reg_q[bit_cnt_q] <= rx_s;
              if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_q <= PARITY;
              else                                    bit_cnt_q <= bit_cnt_d;
            end
          end
          PARITY: begin
            tick_cnt_q <= tick_cnt_d;
            if (tick_last) begin
`ifdef UART_RX_PARITY_CHECK_EN
              par_bit_q <= rx_s;
`endif
              state_q <= STOP;
            end
          end
          STOP: begin
            tick_cnt_q <= tick_cnt_d;
            if (tick_last) begin
              if (rx_s) begin
                data_out_q <= shift_reg_q;
                valid_q    <= 1'b1;
                if (valid_q && !ready) overrun_err_q <= 1'b1;
`ifdef UART_RX_PARITY_CHECK_EN
                parity_err_q <= (par_bit_q != ^shift_reg_q);
`endif
                state_q <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: begin
            // Hold off until the line recovers so a break is not re-read
            // as a stream of start bits.
            if (rx_s) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out    = data_out_q;
  assign valid       = valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_CHECK_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver. The stimulus side acts as the
// transmitter and pushes the expected event for each frame; a monitor
// process pops and compares whenever the DUT loads a byte or flags a
// framing error.
module tb_uart_receiver;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;

`ifdef UART_RX_PARITY_CHECK_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  typedef enum logic {K_BYTE, K_FRAME} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] data;
    logic       par;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  uart_receiver #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rx          (rx),
    .data_out    (data_out),
    .valid       (valid),
    .ready       (ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      sample_tick = (cnt == TICK_DIV - 1);
      cnt = (cnt + 1) % TICK_DIV;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    #1 rx = 1'b1;
    wait_ticks(n);
  endtask

  // Frame bits in line order: start, d[0]..d[7], parity slot, stop.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      #1 rx = f[i];
      wait_ticks(OS);
    end
  endtask

  task automatic push(input kind_e k, input logic [7:0] d, input logic p, input logic o);
    exp_t e;
    e.kind = k; e.data = d; e.par = p; e.ovr = o;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: a load is a rising valid or an overrun (valid stays high).
  initial begin
    logic vp, fp, load;
    exp_t e;
    vp = 1'b0;
    fp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vp = 1'b0;
        fp = 1'b0;
      end else begin
        load = (valid && !vp) || overrun_err;
        if (load) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte: got data %0h want no event", data_out);
          end else begin
            e = exp_q.pop_front();
            check("event_kind_byte", kind_e'(K_BYTE), e.kind);
            check("data_out", data_out, e.data);
            check("parity_err", parity_err, e.par);
            check("overrun_err", overrun_err, e.ovr);
          end
        end
        if (frame_err) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame_err: got pulse want no event");
          end else begin
            e = exp_q.pop_front();
            check("event_kind_frame", kind_e'(K_FRAME), e.kind);
          end
          check("frame_err_one_clk", fp, 1'b0);
        end
        if (parity_err && !load) begin
          total++; bad++;
          $display("FAIL parity_err_without_load: got 1 want 0");
        end
        vp = valid;
        fp = frame_err;
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_overrun_err", overrun_err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Good frame 0xA5, consumer ready
    ready = 1'b1;
    push(K_BYTE, 8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(4);
    drain();
    @(negedge clk);
    check("a5_valid_consumed", valid, 1'b0);

    // 4-tick low glitch while idle: nothing must come out
    #1 rx = 1'b0;
    wait_ticks(4);
    idle(24);
    @(negedge clk);
    check("glitch_valid", valid, 1'b0);
    check("glitch_data_held", data_out, 8'hA5);

    // 0x3C with stop forced low, then a held break, then recovery
    push(K_FRAME, 8'h00, 1'b0, 1'b0);
    send_frame(8'h3C, ^8'h3C, 1'b0);
    wait_ticks(40);
    drain();
    @(negedge clk);
    check("ferr_valid", valid, 1'b0);
    check("ferr_data_held", data_out, 8'hA5);
    idle(4);
    push(K_BYTE, 8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    idle(4);
    drain();

    // Overrun: two frames with ready low
    @(negedge clk);
    ready = 1'b0;
    push(K_BYTE, 8'h11, 1'b0, 1'b0);
    send_frame(8'h11, ^8'h11, 1'b1);
    idle(4);
    push(K_BYTE, 8'h22, 1'b0, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    idle(4);
    drain();
    @(negedge clk);
    check("ovr_valid_held", valid, 1'b1);
    check("ovr_data_out", data_out, 8'h22);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_cleared", valid, 1'b0);

    // Parity slot 0 for 0x01 (even parity wants 1)
    push(K_BYTE, 8'h01, PAR_ON, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(4);
    drain();
    @(negedge clk);
    check("par_data_out", data_out, 8'h01);

    // Reset in the middle of data bit 4, then a clean 0x5A
    begin
      logic [10:0] f;
      f = {1'b1, ^8'hFF, 8'hFF, 1'b0};
      for (int i = 0; i < 5; i++) begin
        #1 rx = f[i];
        wait_ticks(OS);
      end
      #1 rx = f[5];
      wait_ticks(8);
    end
    #1 rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("midrst_valid", valid, 1'b0);
    check("midrst_data_out", data_out, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    @(negedge clk);
    check("postrst_valid", valid, 1'b0);
    push(K_BYTE, 8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    idle(4);
    drain();
    @(negedge clk);
    check("postrst_data_out", data_out, 8'h5A);

    idle(8);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
